// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, divide wait, jump redirect, stall counter.
// Optional RV32M_EN macro builds the DIV_WAIT state and id_ex_hold_o behaviour.
module pipe_ctrl #(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic        id_rs1_used_i,
  input  logic [4:0]  id_rs2_raddr_i,
  input  logic        id_rs2_used_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_div_start_i,
  input  logic        ex_div_done_i,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_bubble_o,
  output logic        if_id_flush_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    DIV_WAIT   = 2'd2,
    REDIRECT   = 2'd3
  } state_t;

  localparam logic [1:0] LAT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t      state, state_n;
  logic [1:0]  lat_cnt, lat_n;
  logic [31:0] stall_cnt_q;
  logic        hazard;

`ifndef RV32M_EN
  logic unused_div;
  assign unused_div = ^{ex_div_start_i, ex_div_done_i};
`endif

  assign hazard = ex_load_i && (ex_rd_i != 5'd0) &&
                  ((id_rs1_used_i && (id_rs1_raddr_i == ex_rd_i)) ||
                   (id_rs2_used_i && (id_rs2_raddr_i == ex_rd_i)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      lat_cnt <= 2'd0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_n;
    end
  end

  // Outputs are forced low while reset is asserted, whatever the inputs show.
  always_comb begin
    state_n        = state;
    lat_n          = lat_cnt;
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    jump_o         = 1'b0;
    jump_addr_o    = 32'd0;
    if (rst) begin
      case (state)
        RUN, REDIRECT: begin
          if (state == REDIRECT) begin
            if_id_flush_o = 1'b1;
            state_n       = RUN;
          end
          if (ex_jump_i) begin
            jump_o         = 1'b1;
            jump_addr_o    = ex_jump_addr_i;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_n        = REDIRECT;
          end else if (state == RUN) begin
`ifdef RV32M_EN
            if (ex_div_start_i) begin
              state_n = DIV_WAIT;
            end else
`endif
            if (hazard) begin
              pc_hold_o      = 1'b1;
              if_id_hold_o   = 1'b1;
              id_ex_bubble_o = 1'b1;
              if (LOAD_LAT > 1) begin
                lat_n   = LAT_INIT;
                state_n = LOAD_STALL;
              end
            end
          end
        end
        // EX holds a bubble here, so jump/divide/hazard inputs are not meaningful.
        LOAD_STALL: begin
          pc_hold_o      = 1'b1;
          if_id_hold_o   = 1'b1;
          id_ex_bubble_o = 1'b1;
          if (lat_cnt == 2'd0) state_n = RUN;
          else                 lat_n   = lat_cnt - 2'd1;
        end
`ifdef RV32M_EN
        DIV_WAIT: begin
          pc_hold_o    = 1'b1;
          if_id_hold_o = 1'b1;
          id_ex_hold_o = 1'b1;
          if (ex_div_done_i) state_n = RUN;
        end
`endif
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   stall_cnt_q <= 32'd0;
    else if (pc_hold_o && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl (LOAD_LAT=2), plus reset and saturation sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1_raddr_i, id_rs2_raddr_i, ex_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_load_i, ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_div_start_i, ex_div_done_i;
  logic        pc_hold_o, if_id_hold_o, id_ex_hold_o, id_ex_bubble_o, if_id_flush_o, jump_o;
  logic [31:0] jump_addr_o, stall_cnt_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_raddr_i(id_rs1_raddr_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_raddr_i(id_rs2_raddr_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
    .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i),
    .ex_div_start_i(ex_div_start_i), .ex_div_done_i(ex_div_done_i),
    .pc_hold_o(pc_hold_o), .if_id_hold_o(if_id_hold_o), .id_ex_hold_o(id_ex_hold_o),
    .id_ex_bubble_o(id_ex_bubble_o), .if_id_flush_o(if_id_flush_o),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o)
  );

  // eo bits: pc_hold, if_id_hold, id_ex_hold, bubble, flush, jump
  typedef struct {
    logic [4:0]  rs1;
    logic        rs1u;
    logic [4:0]  rs2;
    logic        rs2u;
    logic        load;
    logic [4:0]  rd;
    logic        jmp;
    logic [31:0] ja;
    logic        ds;
    logic        dd;
    logic [5:0]  eo;
    logic [31:0] ea;
    logic [31:0] ec;
  } vec_t;

  localparam logic [5:0] Z   = 6'b000000;
  localparam logic [5:0] STL = 6'b110100;
  localparam logic [5:0] JMP = 6'b000111;
  localparam logic [5:0] FL  = 6'b000010;
  localparam logic [5:0] DV  = 6'b111000;

  vec_t tv[$];

  // hz selects the standard load-use pattern: load x5 in EX, ID reads x5 via rs2.
  function automatic vec_t mk(input logic [5:0] eo, input logic [31:0] ec, input logic hz,
                              input logic jmp = 1'b0, input logic [31:0] ja = 32'd0,
                              input logic ds = 1'b0, input logic dd = 1'b0);
    vec_t r;
    r.rs1 = 5'd1; r.rs1u = 1'b0;
    r.rs2 = hz ? 5'd5 : 5'd2; r.rs2u = hz;
    r.load = hz; r.rd = hz ? 5'd5 : 5'd3;
    r.jmp = jmp; r.ja = ja; r.ds = ds; r.dd = dd;
    r.eo = eo; r.ea = eo[0] ? ja : 32'd0; r.ec = ec;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    id_rs1_raddr_i = r.rs1; id_rs1_used_i = r.rs1u;
    id_rs2_raddr_i = r.rs2; id_rs2_used_i = r.rs2u;
    ex_load_i = r.load; ex_rd_i = r.rd;
    ex_jump_i = r.jmp; ex_jump_addr_i = r.ja;
    ex_div_start_i = r.ds; ex_div_done_i = r.dd;
  endtask

  task automatic chk(input string nm, input vec_t r);
    logic [5:0] ao;
    ao = {pc_hold_o, if_id_hold_o, id_ex_hold_o, id_ex_bubble_o, if_id_flush_o, jump_o};
    n_chk++;
    if (ao === r.eo && jump_addr_o === r.ea && stall_cnt_o === r.ec) n_pass++;
    else $display("FAIL %s: got flags=%b addr=%h cnt=%h, want flags=%b addr=%h cnt=%h",
                  nm, ao, jump_addr_o, stall_cnt_o, r.eo, r.ea, r.ec);
  endtask

  initial begin
    vec_t r;
    // load-use via rs2, then via rs1
    tv.push_back(mk(Z, 0, 0));
    tv.push_back(mk(STL, 0, 1));
    tv.push_back(mk(STL, 1, 0));
    tv.push_back(mk(Z, 2, 0));
    r = mk(STL, 2, 0); r.load = 1; r.rd = 5'd7; r.rs1 = 5'd7; r.rs1u = 1; tv.push_back(r);
    tv.push_back(mk(STL, 3, 0));
    tv.push_back(mk(Z, 4, 0));
    // x0 never hazards; unused operands and non-loads do not hazard
    r = mk(Z, 4, 0); r.load = 1; r.rd = 0; r.rs2 = 0; r.rs2u = 1; r.rs1 = 0; r.rs1u = 1; tv.push_back(r);
    r = mk(Z, 4, 1); r.rs2u = 0; r.rs1 = 5'd5; r.rs1u = 0; tv.push_back(r);
    r = mk(Z, 4, 1); r.load = 0; tv.push_back(r);
    // jump: two flushes, no hold
    tv.push_back(mk(JMP, 4, 0, 1, 32'h100));
    tv.push_back(mk(FL, 4, 0));
    tv.push_back(mk(Z, 4, 0));
    // jump beats hazard; jump in REDIRECT re-enters REDIRECT
    tv.push_back(mk(JMP, 4, 1, 1, 32'h200));
    tv.push_back(mk(JMP, 4, 0, 1, 32'h300));
    tv.push_back(mk(FL, 4, 0));
    tv.push_back(mk(Z, 4, 0));
`ifdef RV32M_EN
    tv.push_back(mk(Z, 4, 0, 0, 0, 1));
    tv.push_back(mk(DV, 4, 0));
    tv.push_back(mk(DV, 5, 0));
    tv.push_back(mk(DV, 6, 0, 1, 32'h400));
    tv.push_back(mk(DV, 7, 0));
    tv.push_back(mk(DV, 8, 0));
    tv.push_back(mk(DV, 9, 0));
    tv.push_back(mk(DV, 10, 0, 0, 0, 0, 1));
    tv.push_back(mk(Z, 11, 0));
    tv.push_back(mk(Z, 11, 0, 0, 0, 1));
    tv.push_back(mk(DV, 11, 0, 0, 0, 1, 1));
    tv.push_back(mk(Z, 12, 0));
`else
    tv.push_back(mk(Z, 4, 0, 0, 0, 1));
    for (int i = 0; i < 6; i++) tv.push_back(mk(Z, 4, 0));
    tv.push_back(mk(Z, 4, 0, 0, 0, 0, 1));
    tv.push_back(mk(Z, 4, 0));
`endif

    // reset held with hazard inputs present: outputs stay 0
    drive(mk(Z, 0, 1));
    repeat (3) @(negedge clk);
    chk("reset_hold", mk(Z, 0, 1));
    drive(mk(Z, 0, 0));
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      chk($sformatf("vec%0d", i), tv[i]);
    end

    // asynchronous reset in the middle of LOAD_STALL
    @(negedge clk); drive(mk(Z, 0, 1));
    @(negedge clk); drive(mk(Z, 0, 0));
    #1 r = mk(STL, 0, 0); r.ec = tv[tv.size()-1].ec + 1; chk("ls_before_rst", r);
    #1 rst = 1'b0;
    #1 chk("ls_async_rst", mk(Z, 0, 0));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1 chk("after_rst", mk(Z, 0, 0));

    // saturation: preload near the top, then three hazard-driven stall cycles
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    drive(mk(Z, 0, 1));
    #1 chk("sat0", mk(STL, 32'hFFFF_FFFE, 1));
    @(negedge clk); drive(mk(Z, 0, 0));
    #1 chk("sat1", mk(STL, 32'hFFFF_FFFF, 0));
    @(negedge clk); drive(mk(Z, 0, 1));
    #1 chk("sat2", mk(STL, 32'hFFFF_FFFF, 1));
    @(negedge clk); drive(mk(Z, 0, 0));
    #1 chk("sat3", mk(STL, 32'hFFFF_FFFF, 0));
    @(negedge clk);
    #1 chk("sat_end", mk(Z, 32'hFFFF_FFFF, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the RV32 core. It sits beside the `if_id` / `id` / `ex` stages and drives their hold, bubble and flush controls. It detects load-use hazards on the decode-stage register read addresses, holds the front end while a multi-cycle divide runs in EX, and redirects fetch on a taken jump/branch resolved in EX. It also keeps a saturating count of front-end stall cycles for performance monitoring.

## Interface
Parameters:
- `LOAD_LAT`, 1: bubble cycles per load-use hazard; legal 1..3.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `id_rs1_raddr_i`  in  5  rs1 address of the instruction in ID
- `id_rs1_used_i`  in  1  ID instruction reads rs1
- `id_rs2_raddr_i`  in  5  rs2 address of the instruction in ID
- `id_rs2_used_i`  in  1  ID instruction reads rs2
- `ex_load_i`  in  1  instruction in EX is a load
- `ex_rd_i`  in  5  destination register of the EX instruction
- `ex_jump_i`  in  1  EX resolved a taken jump/branch this cycle
- `ex_jump_addr_i`  in  32  target of that jump
- `ex_div_start_i`  in  1  EX started a multi-cycle divide (1-cycle pulse)
- `ex_div_done_i`  in  1  divide result valid (1-cycle pulse)
- `pc_hold_o`  out  1  PC keeps its value
- `if_id_hold_o`  out  1  `if_id` register keeps its value
- `id_ex_hold_o`  out  1  `id_ex` register keeps its value
- `id_ex_bubble_o`  out  1  `id_ex` loads a NOP (reg_we=0)
- `if_id_flush_o`  out  1  `if_id` loads a NOP
- `jump_o`  out  1  redirect fetch this cycle
- `jump_addr_o`  out  32  redirect target
- `stall_cnt_o`  out  32  cycles with `pc_hold_o`=1

## Operation
- States: RUN, LOAD_STALL, DIV_WAIT, REDIRECT. Reset state RUN. `lat_cnt` (2 b) and `stall_cnt_o` reset to 0.
- Hazard is defined as: `ex_load_i` && `ex_rd_i`!=0 && ((`id_rs1_used_i` && rs1==`ex_rd_i`) || (`id_rs2_used_i` && rs2==`ex_rd_i`)). Register x0 never causes a hazard.
- Priority within a cycle: jump > divide start > hazard.
- RUN:
  - On `ex_jump_i`: `jump_o`=1, `jump_addr_o`=`ex_jump_addr_i`, `if_id_flush_o`=1, `id_ex_bubble_o`=1. Next state is REDIRECT.
  - Otherwise, on `ex_div_start_i`: next state is DIV_WAIT. This cycle's outputs are all 0.
  - Otherwise, on hazard: `pc_hold_o`=`if_id_hold_o`=`id_ex_bubble_o`=1.
    - If `LOAD_LAT`>1: `lat_cnt`<=`LOAD_LAT`-2 and next state is LOAD_STALL.
    - If `LOAD_LAT`=1: stay in RUN.
- LOAD_STALL:
  - `pc_hold_o`=`if_id_hold_o`=`id_ex_bubble_o`=1.
  - When `lat_cnt`==0, go to RUN. Otherwise decrement `lat_cnt`.
  - `ex_jump_i`, `ex_div_start_i` and the hazard inputs are ignored here, because EX holds a bubble.
- DIV_WAIT:
  - `pc_hold_o`=`if_id_hold_o`=`id_ex_hold_o`=1.
  - On `ex_div_done_i`, go to RUN. The hold outputs stay 1 during the done cycle, and the pipeline advances in the next cycle.
  - `ex_jump_i` is ignored.
- REDIRECT:
  - `if_id_flush_o`=1 for one cycle, to kill the instruction in flight from synchronous instruction memory. Next state is RUN.
  - A new `ex_jump_i` in this cycle is handled as in RUN and stays in REDIRECT.
- `jump_addr_o` = 0 whenever `jump_o`=0.
- `stall_cnt_o` increments on every edge where `pc_hold_o`=1 and saturates at 0xFFFFFFFF.

## Timing
- Hold, bubble and flush outputs are combinational from state plus inputs, with zero latency. The stage registers sample them on the same edge.
- The redirect takes effect on the edge after `ex_jump_i`. Exactly 2 `if_id` flushes occur per jump.
- A load-use hazard costs exactly `LOAD_LAT` bubble cycles.
- A divide costs (cycles until `ex_div_done_i`) + 1 held cycles, counted from the start pulse edge.
- If `ex_div_start_i` and `ex_div_done_i` arrive in the same cycle while in DIV_WAIT, done wins.
- Reset asserted mid-operation clears the state to RUN immediately and asynchronously. All outputs go to 0, including `stall_cnt_o`.

## Configuration
- `RV32M_EN` defined: the DIV_WAIT state and the `id_ex_hold_o` behaviour exist as above.
- `RV32M_EN` undefined:
  - DIV_WAIT is not built.
  - `ex_div_start_i` and `ex_div_done_i` are ignored.
  - `id_ex_hold_o` is tied to 0.

## Test plan
- Reset: hold `rst`=0, then release. Required: all outputs 0 and state RUN. Assert `rst`=0 during LOAD_STALL: outputs return to 0 immediately.
- Load-use with `LOAD_LAT`=2: `ex_load_i`=1, `ex_rd_i`=5, `id_rs2_raddr_i`=5, `id_rs2_used_i`=1. Required: `pc_hold_o`/`id_ex_bubble_o` high for exactly 2 cycles and `stall_cnt_o`=2. Repeat with `ex_rd_i`=0: no stall.
- Jump: `ex_jump_i`=1 with addr 0x0000_0100. Required: `jump_o`=1 and `jump_addr_o`=0x100 that cycle, `if_id_flush_o` high 2 consecutive cycles, and no hold.
- Jump plus hazard in the same cycle: only the redirect sequence occurs and `stall_cnt_o` is unchanged.
- Divide (`RV32M_EN`): start pulse, then done 7 cycles later. Required: holds and `id_ex_hold_o` high from the cycle after start through the done cycle (7 cycles), and `ex_jump_i` pulses mid-wait are ignored. Without the macro: no hold at all.
- Saturation: force `stall_cnt_o` to 0xFFFFFFFE and apply 3 hazard cycles. Required: the counter stops at 0xFFFFFFFF.
